// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus arbiter: I/O window decode,
// master limits and the read-return tag carried from grant to rvalid.
package mem_bus_pkg;

  localparam logic [1:0] IO_REGION      = 2'b11;
  localparam int         MAX_MASTERS    = 8;
  localparam int         MAX_ADDR_WIDTH = 64;

  // Tag captured with each read grant, consumed one cycle later.
  typedef struct packed {
    logic       src_is_io;
    logic [2:0] id;
  } rd_tag_t;

  // The I/O window is the top quarter just above the RAM address space:
  // addr[ram_addr_width : ram_addr_width-1] == 2'b11.
  function automatic logic is_io(input logic [MAX_ADDR_WIDTH-1:0] addr,
                                 input int ram_addr_width);
    logic [MAX_ADDR_WIDTH-1:0] shifted;
    shifted = addr >> (ram_addr_width - 1);
    return shifted[1:0] == IO_REGION;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible master at or
// after rr_ptr (wrapping), or only the lock owner while a lock is held.
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] eligible,
  input  logic [2:0]             rr_ptr,
  input  logic                   lock_hold,
  input  logic [2:0]             lock_owner,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic                   gnt_valid,
  output logic [2:0]             gnt_idx,
  output logic [2:0]             next_ptr
);

  logic [NUM_MASTERS-1:0] masked;

  // Two passes over the masters: first from rr_ptr upward, then the wrap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front,
    // so no path through the block can leave a value unassigned (no latch).
    masked    = eligible;
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (lock_hold) masked = eligible & (NUM_MASTERS'(1) << lock_owner);
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!gnt_valid && masked[i] && 3'(i) >= rr_ptr) begin
        gnt_valid = 1'b1;
        gnt_idx   = 3'(i);
        gnt[i]    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!gnt_valid && masked[i] && 3'(i) < rr_ptr) begin
        gnt_valid = 1'b1;
        gnt_idx   = 3'(i);
        gnt[i]    = 1'b1;
      end
    end
    next_ptr = rr_ptr;
    if (gnt_valid && !lock_hold)
      next_ptr = (gnt_idx == 3'(NUM_MASTERS - 1)) ? 3'd0 : gnt_idx + 3'd1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master memory-bus arbiter and RAM / I/O decoder with a registered,
// ID-tagged read-return path. Host access preempts every master.
// Optional feature: define MEM_BUS_LOCK_EN to let a master hold its grant
// across consecutive requests via m_lock.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             host_active,
  input  logic [NUM_MASTERS-1:0]           m_req,
  input  logic [NUM_MASTERS-1:0]           m_wr,
  input  logic [NUM_MASTERS-1:0]           m_lock,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]           m_gnt,
  output logic                             rvalid,
  output logic [2:0]                       rid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [RAM_ADDR_WIDTH-1:0]        ram_addr,
  output logic                             ram_we,
  output logic [DATA_WIDTH-1:0]            ram_din,
  input  logic [DATA_WIDTH-1:0]            ram_dout,
  output logic                             io_en,
  output logic [2:0]                       io_sel,
  output logic                             io_wr,
  output logic [DATA_WIDTH-1:0]            io_din,
  input  logic [DATA_WIDTH-1:0]            io_dout,
  input  logic                             io_full
);

  localparam int SW = RAM_ADDR_WIDTH + 1;  // address bits the decode needs

  logic [NUM_MASTERS-1:0] eligible, arb_gnt;
  logic                   gnt_valid, issue, io_region, lock_hold;
  logic [2:0]             gnt_idx, next_ptr, rr_ptr, lock_owner;
  logic [SW-1:0]          sel_addr, addr_q;
  logic [DATA_WIDTH-1:0]  sel_wdata, wdata_q;
  logic                   sel_wr, wr_q;
  rd_tag_t                tag_q;
  logic                   unused_inputs;

  // Address bits above the I/O window never matter to the decode.
  assign unused_inputs = ^{m_addr, m_lock};

  // Eligibility: requests, minus I/O writes stalled by io_full; none for host.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      eligible[i] = m_req[i] & ~(m_wr[i] & io_full &
                    is_io(MAX_ADDR_WIDTH'(m_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
                          RAM_ADDR_WIDTH));
    if (host_active) eligible = '0;
  end

  rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr_arbiter (
    .eligible   (eligible),
    .rr_ptr     (rr_ptr),
    .lock_hold  (lock_hold),
    .lock_owner (lock_owner),
    .gnt        (arb_gnt),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .next_ptr   (next_ptr)
  );

`ifdef MEM_BUS_LOCK_EN
  logic       lock_valid;
  logic [2:0] lock_owner_q;

  assign lock_owner = lock_owner_q;

  // Lock stays in force while the owner keeps both m_req and m_lock high.
  always_comb begin
    lock_hold = lock_valid & ~host_active &
                (|((NUM_MASTERS'(1) << lock_owner_q) & m_req & m_lock));
  end

  // Lock owner register: taken on a locked grant, dropped on release or host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid   <= 1'b0;
      lock_owner_q <= '0;
    end else if (host_active) begin
      lock_valid   <= 1'b0;
    end else if (issue && (|(arb_gnt & m_lock))) begin
      lock_valid   <= 1'b1;
      lock_owner_q <= gnt_idx;
    end else if (!lock_hold) begin
      lock_valid   <= 1'b0;
    end
  end
`else
  assign lock_hold  = 1'b0;
  assign lock_owner = '0;
`endif

  assign issue = gnt_valid & rst_n;

  // Bus fields follow the granted master, otherwise hold their last values.
  always_comb begin
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    sel_wr    = wr_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_valid && gnt_idx == 3'(i)) begin
        sel_addr  = m_addr[i*ADDR_WIDTH +: SW];
        sel_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wr    = m_wr[i];
      end
    end
  end

  assign io_region = is_io(MAX_ADDR_WIDTH'(sel_addr), RAM_ADDR_WIDTH);

  assign m_gnt    = rst_n ? arb_gnt : '0;
  assign ram_we   = issue & sel_wr & ~io_region;
  assign io_en    = issue & io_region;
  assign io_wr    = sel_wr;
  assign io_sel   = sel_addr[2:0];
  assign ram_addr = sel_addr[RAM_ADDR_WIDTH-1:0];
  assign ram_din  = sel_wdata;
  assign io_din   = sel_wdata;

  // Pointer, held bus fields and the read-return tag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      rr_ptr  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rvalid  <= 1'b0;
      tag_q   <= '0;
    end else begin
      rr_ptr  <= next_ptr;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      wr_q    <= sel_wr;
      rvalid  <= gnt_valid & ~sel_wr;
      if (gnt_valid && !sel_wr) tag_q <= '{src_is_io: io_region, id: gnt_idx};
    end
  end

  assign rid   = tag_q.id;
  assign rdata = tag_q.src_is_io ? io_dout : ram_dout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with three masters: reset, rotation,
// host preemption, reset during a read, I/O back-pressure, I/O read, RAM
// write and (when MEM_BUS_LOCK_EN is defined) grant locking.
module tb_mem_bus_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int RAW = 17;
  localparam int DW  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            host_active;
  logic [N-1:0]    m_req, m_wr, m_lock, m_gnt;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic            rvalid, ram_we, io_en, io_wr, io_full;
  logic [2:0]      rid, io_sel;
  logic [DW-1:0]   rdata, ram_din, ram_dout, io_din, io_dout;
  logic [RAW-1:0]  ram_addr;

  int checks   = 0;
  int failures = 0;

  logic [2:0] rot_gnt   [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
  logic [2:0] rot_rid   [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
  logic [7:0] rot_rdata [4] = '{8'h01, 8'h02, 8'h03, 8'h01};

  always #5 clk = ~clk;

  // Synchronous RAM stand-in: byte = addr[15:8] ^ addr[7:0], 1-cycle latency.
  always @(posedge clk) ram_dout <= ram_addr[15:8] ^ ram_addr[7:0];

  mem_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host_active(host_active),
    .m_req(m_req), .m_wr(m_wr), .m_lock(m_lock), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .rvalid(rvalid), .rid(rid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .io_en(io_en), .io_sel(io_sel), .io_wr(io_wr),
    .io_din(io_din), .io_dout(io_dout), .io_full(io_full)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic req, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    m_req[i]              = req;
    m_wr[i]               = wr;
    m_addr[i*AW +: AW]    = addr;
    m_wdata[i*DW +: DW]   = wd;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; host_active = 1'b0; io_full = 1'b0; io_dout = 8'hC5;
    m_req = '0; m_wr = '0; m_lock = '0; m_addr = '0; m_wdata = '0;
    set_m(0, 1'b1, 1'b0, 32'h100, 8'h00);
    set_m(1, 1'b1, 1'b0, 32'h200, 8'h00);
    set_m(2, 1'b1, 1'b0, 32'h300, 8'h00);

    // Reset with every master requesting.
    tick(); tick(); #1;
    check("rst_gnt", 32'(m_gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_io_en", 32'(io_en), 32'h0);

    // Release: master 0 first, then rotation with 1-cycle read returns.
    tick(); rst_n = 1'b1; #1;
    check("first_gnt", 32'(m_gnt), 32'h1);
    check("first_ram_addr", 32'(ram_addr), 32'h100);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check($sformatf("rot%0d_gnt", k), 32'(m_gnt), 32'(rot_gnt[k]));
      check($sformatf("rot%0d_rvalid", k), 32'(rvalid), 32'h1);
      check($sformatf("rot%0d_rid", k), 32'(rid), 32'(rot_rid[k]));
      check($sformatf("rot%0d_rdata", k), 32'(rdata), 32'(rot_rdata[k]));
    end

    // Host preemption for 5 cycles; the read granted to master 1 still returns.
    tick(); host_active = 1'b1; #1;
    check("host0_gnt", 32'(m_gnt), 32'h0);
    check("host0_ram_we", 32'(ram_we), 32'h0);
    check("host0_rvalid", 32'(rvalid), 32'h1);
    check("host0_rid", 32'(rid), 32'h1);
    check("host0_rdata", 32'(rdata), 32'h02);
    for (int k = 1; k < 5; k++) begin
      tick(); #1;
      check($sformatf("host%0d_gnt", k), 32'(m_gnt), 32'h0);
      check($sformatf("host%0d_rvalid", k), 32'(rvalid), 32'h0);
    end
    tick(); host_active = 1'b0; #1;
    check("resume_gnt", 32'(m_gnt), 32'h4);
    tick(); #1;
    check("resume_next_gnt", 32'(m_gnt), 32'h1);
    check("resume_rid", 32'(rid), 32'h2);
    check("resume_rdata", 32'(rdata), 32'h03);

    // Reset asserted while master 0's read is returning drops it at once.
    tick(); #1;
    check("pre_rst_rvalid", 32'(rvalid), 32'h1);
    rst_n = 1'b0; #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'h0);
    check("mid_rst_gnt", 32'(m_gnt), 32'h0);

    // I/O back-pressure: master 1 writes the I/O window while io_full is set.
    set_m(0, 1'b1, 1'b0, 32'h100, 8'h00);
    set_m(1, 1'b1, 1'b1, 32'h30000, 8'hAB);
    set_m(2, 1'b0, 1'b0, 32'h300, 8'h00);
    io_full = 1'b1;
    tick(); rst_n = 1'b1; #1;
    check("bp0_gnt", 32'(m_gnt), 32'h1);
    tick(); #1;
    check("bp1_gnt", 32'(m_gnt), 32'h1);
    check("bp1_io_en", 32'(io_en), 32'h0);
    check("bp1_rdata", 32'(rdata), 32'h01);
    tick(); io_full = 1'b0; #1;
    check("bp2_gnt", 32'(m_gnt), 32'h2);
    check("bp2_io_en", 32'(io_en), 32'h1);
    check("bp2_io_wr", 32'(io_wr), 32'h1);
    check("bp2_io_sel", 32'(io_sel), 32'h0);
    check("bp2_io_din", 32'(io_din), 32'hAB);
    check("bp2_ram_we", 32'(ram_we), 32'h0);
    tick(); m_req = '0; #1;
    check("idle_gnt", 32'(m_gnt), 32'h0);
    check("idle_rvalid_after_write", 32'(rvalid), 32'h0);
    check("idle_io_en", 32'(io_en), 32'h0);
    check("idle_ram_addr_hold", 32'(ram_addr), 32'h10000);

    // I/O read from master 0 returns io_dout, not the RAM byte.
    tick(); set_m(0, 1'b1, 1'b0, 32'h30004, 8'h00); #1;
    check("ior_gnt", 32'(m_gnt), 32'h1);
    check("ior_io_en", 32'(io_en), 32'h1);
    check("ior_io_wr", 32'(io_wr), 32'h0);
    check("ior_io_sel", 32'(io_sel), 32'h4);
    check("ior_ram_we", 32'(ram_we), 32'h0);
    tick(); m_req = '0; #1;
    check("ior_rvalid", 32'(rvalid), 32'h1);
    check("ior_rid", 32'(rid), 32'h0);
    check("ior_rdata", 32'(rdata), 32'hC5);

    // Plain RAM write from master 2.
    tick(); set_m(2, 1'b1, 1'b1, 32'h300, 8'h77); #1;
    check("ramw_gnt", 32'(m_gnt), 32'h4);
    check("ramw_ram_we", 32'(ram_we), 32'h1);
    check("ramw_ram_addr", 32'(ram_addr), 32'h300);
    check("ramw_ram_din", 32'(ram_din), 32'h77);
    check("ramw_io_en", 32'(io_en), 32'h0);
    tick(); m_req = '0; #1;
    check("ramw_rvalid", 32'(rvalid), 32'h0);
    check("ramw_idle_we", 32'(ram_we), 32'h0);

    // Master 1 asserts m_lock while all three masters read.
    tick(); rst_n = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h100, 8'h00);
    set_m(1, 1'b1, 1'b0, 32'h200, 8'h00);
    set_m(2, 1'b1, 1'b0, 32'h300, 8'h00);
    m_lock = 3'b010;
    tick(); rst_n = 1'b1; #1;
    check("lock_first_gnt", 32'(m_gnt), 32'h1);
`ifdef MEM_BUS_LOCK_EN
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check($sformatf("lock%0d_gnt", k), 32'(m_gnt), 32'h2);
    end
    tick(); m_lock = '0; #1;
    check("unlock_gnt", 32'(m_gnt), 32'h4);
`else
    tick(); #1;
    check("nolock_gnt1", 32'(m_gnt), 32'h2);
    tick(); #1;
    check("nolock_gnt2", 32'(m_gnt), 32'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised memory-bus arbiter and address decoder between N byte-wide masters and the shared 128 KiB synchronous RAM plus the memory-mapped I/O window. It generalises the single-master top-level bus muxing to a round-robin arbiter with host preemption, I/O back-pressure and a registered read-return path tagged by master ID. It sits in the top level between the CPU-side ports (instruction/data) and `single_port_ram_sync` / `hci`.

## Interface
- `NUM_MASTERS`, 2: number of requesting masters (1..8).
- `ADDR_WIDTH`, 32: master address width.
- `RAM_ADDR_WIDTH`, 17: RAM address width; I/O window is `addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11`.
- `DATA_WIDTH`, 8: data width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `host_active`  in  1  host (HCI) owns RAM; preempts all masters.
- `m_req`  in  NUM_MASTERS  per-master request.
- `m_wr`  in  NUM_MASTERS  1 = write.
- `m_lock`  in  NUM_MASTERS  hold grant across consecutive requests (see Configuration).
- `m_addr`  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at slice i.
- `m_wdata`  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- `m_gnt`  out  NUM_MASTERS  one-hot grant, access issued this cycle.
- `rvalid`  out  1  read data valid.
- `rid`  out  3  master index of returned read.
- `rdata`  out  DATA_WIDTH  read data.
- `ram_addr`  out  RAM_ADDR_WIDTH, `ram_we` out 1, `ram_din` out DATA_WIDTH, `ram_dout` in DATA_WIDTH: RAM port (1-cycle read latency).
- `io_en` out 1, `io_sel` out 3, `io_wr` out 1, `io_din` out DATA_WIDTH, `io_dout` in DATA_WIDTH, `io_full` in 1: I/O port.

## Operation
- Per cycle: if `host_active`=1 → `m_gnt`=0, `ram_we`=0, `io_en`=0, pointer frozen.
- Otherwise, eligible = `m_req` minus masters issuing an I/O write while `io_full`=1. Grant the first eligible index at or after `rr_ptr`, wrapping modulo NUM_MASTERS.
- On grant of master g: `rr_ptr` ← (g+1) mod NUM_MASTERS; the RAM/IO outputs carry master g's fields. `ram_we` = `m_wr[g]` & ~io_region; `io_en` = io_region; `io_wr` = `m_wr[g]`; `io_sel` = `addr[2:0]`.
- When no grant, `ram_we`=0, `io_en`=0, and the address/data outputs hold the last values.
- A read grant registers `{src_is_io, g}`. Next cycle: `rvalid`=1, `rid`=g, `rdata` = `io_dout` if src_is_io else `ram_dout`.
- A write produces no `rvalid`.
- Reset values: `rr_ptr`=0, `rvalid`=0, `rid`=0, src_is_io=0, lock owner none. While `rst_n`=0, `m_gnt`, `ram_we` and `io_en` are forced 0.

## Timing
- Grant is combinational from `m_req`, `rr_ptr`, `host_active` and `io_full`. The master drops or changes its request the cycle after it sees `m_gnt`.
- Read latency: exactly 1 cycle from grant to `rvalid`. At most one new read is issued per cycle.
- `host_active` rising while a read is outstanding: the outstanding `rvalid` still fires next cycle; no new grants follow.
- Reset asserted mid-read: the return is dropped and `rvalid` goes 0 immediately.
- NUM_MASTERS=1: the pointer is constant 0 and the block degenerates to the plain single-master mux.

## Configuration
- `MEM_BUS_LOCK_EN` defined:
  - When a master is granted with `m_lock`=1, it becomes lock owner.
  - While the owner holds `m_req`&`m_lock`, only it is eligible and `rr_ptr` is frozen.
  - Lock releases when the owner deasserts `m_lock` or `m_req`, or when `host_active`=1.
- `MEM_BUS_LOCK_EN` undefined: `m_lock` is ignored and there is no lock-owner register.

## Structure
- Shared package `mem_bus_pkg`:
  - `IO_REGION` = 2'b11.
  - `MAX_MASTERS` = 8.
  - Typedef `rd_tag_t` {src_is_io, id[2:0]}.
  - Function `is_io(addr)`.
- One sub-module `rr_arbiter` (NUM_MASTERS): inputs eligible, rr_ptr, lock state; outputs one-hot grant and next pointer.
- Muxing, decode and the return register stay in `mem_bus_arbiter`.

## Test plan
- Reset: `rst_n`=0 with all `m_req`=1 → `m_gnt`=0, `rvalid`=0, `ram_we`=0. Release → first grant goes to master 0.
- Contention: NUM_MASTERS=3, all requesting reads of 0x100/0x200/0x300 continuously → grants 0,1,2,0… Each `rvalid` follows its grant by 1 cycle with the matching `rid` and RAM byte.
- I/O back-pressure: master 1 writes 0x30000 with `io_full`=1 while master 0 reads RAM → only master 0 is granted. Drop `io_full` → master 1 gets `io_en`=1, `io_wr`=1, `io_sel`=0.
- I/O read: master 0 reads 0x30004 → `io_sel`=4. Next cycle `rdata`=`io_dout`, not `ram_dout`.
- Host preemption: `host_active`=1 for 5 cycles during contention → no grants, pointer unchanged. Rotation resumes at the saved pointer.
- With `MEM_BUS_LOCK_EN`: master 1 holds `m_lock` for 4 requests → 4 consecutive grants to 1. Unlock → master 2 is granted next.
